// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, fault causes, LSU state and op payload.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] lane;
        logic [4:0] rd;
    } lsu_op_t;

    // Stores only know B/H/W; loads additionally accept BU/HU.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic res;
        if (is_store) res = (f3 > F3_W);
        else          res = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                              f3 == F3_BU || f3 == F3_HU);
        return res;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic res;
        case (f3[1:0])
            2'b01:   res = lane[0];
            2'b10:   res = (lane != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Execute-stage request, data-memory and write-back signals of the load/store unit.
interface lsu_mem_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        output req_valid, is_store, funct3, addr, store_data, rd, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               wb_valid, wb_rd, wb_data, stall, fault, fault_cause
    );

    modport slave (
        input  req_valid, is_store, funct3, addr, store_data, rd, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               wb_valid, wb_rd, wb_data, stall, fault, fault_cause
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extraction.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_load = i_rdata;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'h000000, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'h0000, w_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit: validates ops, runs one req/ack memory access with timeout,
// and returns extended load data to the register-file write port.
module lsu_mem_stage
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RESET_WB = 32'h0000_0000
) (
    input logic         clk,
    input logic         reset,
    lsu_mem_stage_if.slave bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e       r_state;
    lsu_op_t          r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_stall;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;
    logic             r_fault;
    logic [1:0]       r_fault_cause;

    logic [2:0]  w_f3;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic        w_illegal;
    logic        w_misaligned;

    // The aligner serves the incoming op while idle and the latched op during the access.
    always_comb begin
        w_f3         = (r_state == ST_IDLE) ? bus.funct3    : r_op.funct3;
        w_lane       = (r_state == ST_IDLE) ? bus.addr[1:0] : r_op.lane;
        w_illegal    = f3_illegal(bus.is_store, bus.funct3);
        w_misaligned = f3_misaligned(bus.funct3, bus.addr[1:0]);
    end

    lsu_align u_align (
        .i_funct3 (w_f3),
        .i_lane   (w_lane),
        .i_wdata  (bus.store_data),
        .i_rdata  (bus.mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_load   (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_stall       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= RESET_WB;
            r_fault       <= 1'b0;
            r_fault_cause <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_illegal) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= CAUSE_ILLEGAL;
                        end else if (w_misaligned) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= CAUSE_MISALIGN;
                        end else begin
                            r_op        <= '{is_store: bus.is_store, funct3: bus.funct3,
                                             lane: bus.addr[1:0], rd: bus.rd};
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.is_store;
                            r_mem_addr  <= {bus.addr[31:2], 2'b00};
                            r_mem_wdata <= bus.is_store ? w_wdata : 32'h0000_0000;
                            r_mem_be    <= bus.is_store ? w_be : 4'hF;
                            r_cnt       <= '0;
                            r_req_ready <= 1'b0;
                            r_stall     <= 1'b1;
                            r_state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                        if (!r_op.is_store && r_op.rd != 5'd0) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_op.rd;
                            r_wb_data  <= w_load;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_mem_req     <= 1'b0;
                        r_fault       <= 1'b1;
                        r_fault_cause <= CAUSE_TIMEOUT;
                        r_req_ready   <= 1'b1;
                        r_stall       <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_stall     <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mem_req   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_stall     <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.stall       = r_stall;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_be      = r_mem_be;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.fault       = r_fault;
    assign bus.fault_cause = r_fault_cause;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus a randomized op stream,
// expectations queued from an independent reference model.
module tb_lsu_mem_stage;
    import rv32_pkg::*;

    localparam int          TO  = 4;
    localparam logic [31:0] RWB = 32'hCAFE_0001;

    typedef struct packed {
        logic        fault;
        logic [1:0]  cause;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          req_cycles;
        int          stall_cycles;
    } exp_t;

    typedef struct packed {
        int          wb_cnt;
        int          wb_cycle;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        int          fault_cnt;
        int          fault_cycle;
        logic [1:0]  cause;
        int          req_cycles;
        int          stall_cycles;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        stable;
        logic        ready_ok;
        logic        ready0;
        logic        done;
    } obs_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];
    logic [31:0] held_wb;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.TIMEOUT(TO), .RESET_WB(RWB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [4:0] r,
                                   input logic [31:0] word, input int ack_at);
        exp_t        e;
        logic [31:0] sh;
        logic        ill;
        logic        mis;
        e   = '0;
        ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        if (ill || mis) begin
            e.fault = 1'b1;
            e.cause = ill ? 2'b11 : 2'b01;
            return e;
        end
        e.maddr = a & 32'hFFFF_FFFC;
        e.we    = st;
        e.be    = 4'hF;
        if (st) begin
            case (f3)
                3'd0:    begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{sd[7:0]}}; end
                3'd1:    begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{sd[15:0]}}; end
                default: e.wdata = sd;
            endcase
        end
        if (ack_at >= 1 && ack_at <= TO) begin
            e.req_cycles   = ack_at;
            e.stall_cycles = ack_at + 1;
            if (!st && r != 5'd0) begin
                e.wb = 1'b1;
                e.rd = r;
                sh   = word >> {a[1:0], 3'b000};
                case (f3)
                    3'd0:    e.data = {{24{sh[7]}}, sh[7:0]};
                    3'd4:    e.data = {24'h0, sh[7:0]};
                    3'd1:    e.data = {{16{sh[15]}}, sh[15:0]};
                    3'd5:    e.data = {16'h0, sh[15:0]};
                    default: e.data = word;
                endcase
            end
        end else begin
            e.req_cycles   = TO;
            e.stall_cycles = TO;
            e.fault        = 1'b1;
            e.cause        = 2'b10;
        end
        return e;
    endfunction

    // Issues one op, plays memory (ack on req cycle ack_at, 0 = never) and records what the DUT did.
    task automatic drive_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [4:0] r,
                            input logic [31:0] word, input int ack_at, output obs_t o);
        o          = '0;
        o.stable   = 1'b1;
        o.ready_ok = 1'b1;
        bus.req_valid  = 1'b1;
        bus.is_store   = st;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
        bus.rd         = r;
        o.ready0       = bus.req_ready;
        tick();
        bus.req_valid  = 1'b0;
        bus.store_data = 32'h1357_9BDF;
        for (int c = 1; c <= 20; c++) begin
            if (bus.mem_req) begin
                if (o.req_cycles == 0) begin
                    o.maddr = bus.mem_addr; o.be = bus.mem_be;
                    o.wdata = bus.mem_wdata; o.we = bus.mem_we;
                end else if (o.maddr !== bus.mem_addr || o.be !== bus.mem_be ||
                             o.wdata !== bus.mem_wdata || o.we !== bus.mem_we) begin
                    o.stable = 1'b0;
                end
                o.req_cycles++;
            end
            if (bus.stall) o.stall_cycles++;
            if (bus.req_ready !== !bus.stall) o.ready_ok = 1'b0;
            if (bus.wb_valid) begin
                o.wb_cnt++; o.wb_cycle = c; o.wb_rd = bus.wb_rd; o.wb_data = bus.wb_data;
            end
            if (bus.fault) begin
                o.fault_cnt++; o.fault_cycle = c; o.cause = bus.fault_cause;
            end
            if (!bus.stall) begin
                o.done = 1'b1;
                break;
            end
            bus.mem_ack   = (c == ack_at);
            bus.mem_rdata = (c == ack_at) ? word : 32'h5A5A_0F0F;
            tick();
            bus.mem_ack   = 1'b0;
        end
    endtask

    task automatic test_reset();
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.wb_valid !== 1'b0 || bus.fault !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: req=%b stall=%b wbv=%b fault=%b want 0000",
                            bus.mem_req, bus.stall, bus.wb_valid, bus.fault);
        end
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        total++;
        if (bus.wb_data !== RWB) begin bad++; $display("FAIL reset_wb_data: got %h want %h", bus.wb_data, RWB); end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.wb_rd, bus.fault_cause, bus.mem_we} !== '0) begin
            bad++; $display("FAIL reset_regs: addr=%h wdata=%h be=%h rd=%0d cause=%b we=%b want zero",
                            bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.wb_rd, bus.fault_cause, bus.mem_we);
        end
        total++;
    endtask

    task automatic test_lb();
        obs_t o;
        exp_t e;
        q.push_back(model(1'b0, F3_B, 32'h0000_0103, 32'h0, 5'd5, 32'h80FF_FF7F, 1));
        drive_op(1'b0, F3_B, 32'h0000_0103, 32'h0, 5'd5, 32'h80FF_FF7F, 1, o);
        e = q.pop_front();
        total++;
        if (o.maddr !== 32'h0000_0100) begin bad++; $display("FAIL lb_addr: got %h want 00000100", o.maddr); end
        total++;
        if (o.wb_cnt !== 1 || o.wb_cycle !== 2) begin
            bad++; $display("FAIL lb_wb_timing: count=%0d cycle=%0d want 1 at 2", o.wb_cnt, o.wb_cycle);
        end
        total++;
        if (o.wb_rd !== 5'd5 || o.wb_data !== 32'hFFFF_FF80 || o.wb_data !== e.data) begin
            bad++; $display("FAIL lb_data: rd=%0d data=%h want 5 ffffff80", o.wb_rd, o.wb_data);
        end
        total++;
        if (o.be !== 4'hF || o.we !== 1'b0 || o.ready0 !== 1'b1) begin
            bad++; $display("FAIL lb_be_we: be=%h we=%b ready=%b want f 0 1", o.be, o.we, o.ready0);
        end
        held_wb = 32'hFFFF_FF80;
    endtask

    task automatic test_lhu_delayed();
        obs_t o;
        exp_t e;
        q.push_back(model(1'b0, F3_HU, 32'h0000_0202, 32'h0, 5'd9, 32'hBEEF_1234, 3));
        drive_op(1'b0, F3_HU, 32'h0000_0202, 32'h0, 5'd9, 32'hBEEF_1234, 3, o);
        e = q.pop_front();
        total++;
        if (o.stall_cycles !== 4 || o.stall_cycles !== e.stall_cycles) begin
            bad++; $display("FAIL lhu_stall: got %0d want 4", o.stall_cycles);
        end
        total++;
        if (o.wb_data !== 32'h0000_BEEF || o.wb_rd !== 5'd9) begin
            bad++; $display("FAIL lhu_data: rd=%0d data=%h want 9 0000beef", o.wb_rd, o.wb_data);
        end
        total++;
        if (o.ready_ok !== 1'b1 || o.stable !== 1'b1 || o.req_cycles !== 3) begin
            bad++; $display("FAIL lhu_hold: ready_ok=%b stable=%b req=%0d want 1 1 3", o.ready_ok, o.stable, o.req_cycles);
        end
        held_wb = 32'h0000_BEEF;
    endtask

    task automatic test_sb();
        obs_t o;
        exp_t e;
        q.push_back(model(1'b1, F3_B, 32'h0000_0301, 32'h0000_00A5, 5'd3, 32'h0, 1));
        drive_op(1'b1, F3_B, 32'h0000_0301, 32'h0000_00A5, 5'd3, 32'hFFFF_FFFF, 1, o);
        e = q.pop_front();
        total++;
        if (o.we !== 1'b1 || o.be !== 4'b0010 || o.wdata !== 32'hA5A5_A5A5 || o.maddr !== 32'h300) begin
            bad++; $display("FAIL sb_bus: we=%b be=%b wdata=%h addr=%h want 1 0010 a5a5a5a5 300",
                            o.we, o.be, o.wdata, o.maddr);
        end
        total++;
        if (o.wb_cnt !== 0 || o.fault_cnt !== 0 || bus.wb_data !== held_wb) begin
            bad++; $display("FAIL sb_no_wb: wb=%0d fault=%0d data=%h want 0 0 %h", o.wb_cnt, o.fault_cnt, bus.wb_data, held_wb);
        end
        total++;
        if (o.be !== e.be) begin bad++; $display("FAIL sb_model_be: got %b want %b", o.be, e.be); end
    endtask

    task automatic test_faults();
        obs_t o;
        exp_t e;
        q.push_back(model(1'b0, F3_W, 32'h0000_0402, 32'h0, 5'd4, 32'h0, 1));
        drive_op(1'b0, F3_W, 32'h0000_0402, 32'h0, 5'd4, 32'h0, 1, o);
        e = q.pop_front();
        total++;
        if (o.fault_cnt !== 1 || o.fault_cycle !== 1 || o.cause !== 2'b01 || o.cause !== e.cause) begin
            bad++; $display("FAIL lw_misalign: n=%0d cyc=%0d cause=%b want 1 1 01", o.fault_cnt, o.fault_cycle, o.cause);
        end
        total++;
        if (o.req_cycles !== 0 || o.stall_cycles !== 0) begin
            bad++; $display("FAIL lw_misalign_noreq: req=%0d stall=%0d want 0 0", o.req_cycles, o.stall_cycles);
        end
        drive_op(1'b1, 3'b011, 32'h0000_0410, 32'h0, 5'd4, 32'h0, 1, o);
        total++;
        if (o.fault_cnt !== 1 || o.cause !== 2'b11 || o.req_cycles !== 0) begin
            bad++; $display("FAIL st_illegal: n=%0d cause=%b req=%0d want 1 11 0", o.fault_cnt, o.cause, o.req_cycles);
        end
        drive_op(1'b0, 3'b110, 32'h0000_0413, 32'h0, 5'd4, 32'h0, 1, o);
        total++;
        if (o.cause !== 2'b11) begin bad++; $display("FAIL illegal_priority: cause=%b want 11", o.cause); end
        drive_op(1'b1, F3_H, 32'h0000_0421, 32'h0, 5'd4, 32'h0, 1, o);
        total++;
        if (o.cause !== 2'b01 || o.req_cycles !== 0) begin
            bad++; $display("FAIL sh_misalign: cause=%b req=%0d want 01 0", o.cause, o.req_cycles);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_op(1'b0, F3_W, 32'h0000_0500, 32'h0, 5'd6, 32'h1111_2222, 0, o);
        total++;
        if (o.req_cycles !== TO || o.fault_cnt !== 1 || o.cause !== 2'b10 || o.fault_cycle !== TO + 1) begin
            bad++; $display("FAIL timeout: req=%0d n=%0d cause=%b cyc=%0d want %0d 1 10 %0d",
                            o.req_cycles, o.fault_cnt, o.cause, o.fault_cycle, TO, TO + 1);
        end
        total++;
        if (o.wb_cnt !== 0 || o.done !== 1'b1 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL timeout_idle: wb=%0d done=%b ready=%b want 0 1 1", o.wb_cnt, o.done, bus.req_ready);
        end
        drive_op(1'b0, F3_W, 32'h0000_0504, 32'h0, 5'd6, 32'h1111_2222, TO, o);
        total++;
        if (o.fault_cnt !== 0 || o.wb_cnt !== 1 || o.wb_data !== 32'h1111_2222 || o.req_cycles !== TO) begin
            bad++; $display("FAIL ack_at_limit: fault=%0d wb=%0d data=%h req=%0d want 0 1 11112222 %0d",
                            o.fault_cnt, o.wb_cnt, o.wb_data, o.req_cycles, TO);
        end
        held_wb = 32'h1111_2222;
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        bus.req_valid = 1'b1; bus.is_store = 1'b0; bus.funct3 = F3_W;
        bus.addr = 32'h0000_0600; bus.rd = 5'd7;
        tick();
        bus.req_valid = 1'b0;
        tick();
        total++;
        if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL mid_access_req: got %b want 1", bus.mem_req); end
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset: req=%b stall=%b ready=%b want 0 0 1", bus.mem_req, bus.stall, bus.req_ready);
        end
        tick();
        #2 reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.wb_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.fault !== 1'b0) begin
                bad++; $display("FAIL stale_ack: wbv=%b req=%b stall=%b fault=%b want 0 0 0 0",
                                bus.wb_valid, bus.mem_req, bus.stall, bus.fault);
            end
        end
        bus.mem_ack = 1'b0;
        drive_op(1'b0, F3_W, 32'h0000_0700, 32'h0, 5'd0, 32'h9999_9999, 1, o);
        total++;
        if (o.wb_cnt !== 0 || o.req_cycles !== 1 || o.stall_cycles !== 2 || bus.wb_data !== RWB) begin
            bad++; $display("FAIL rd0_load: wb=%0d req=%0d stall=%0d data=%h want 0 1 2 %h",
                            o.wb_cnt, o.req_cycles, o.stall_cycles, bus.wb_data, RWB);
        end
        held_wb = RWB;
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        exp_t        e;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] word;
        logic [4:0]  r;
        int          ack_at;
        for (int n = 0; n < 60; n++) begin
            st     = 1'($urandom_range(0, 1));
            f3     = 3'($urandom_range(0, 7));
            a      = $urandom;
            sd     = $urandom;
            word   = $urandom;
            r      = 5'($urandom_range(0, 31));
            ack_at = $urandom_range(0, 5);
            q.push_back(model(st, f3, a, sd, r, word, ack_at));
            drive_op(st, f3, a, sd, r, word, ack_at, o);
            e = q.pop_front();
            if (e.wb) held_wb = e.data;
            total++;
            if (o.fault_cnt !== int'(e.fault) || (e.fault && o.cause !== e.cause)) begin
                bad++; $display("FAIL rnd%0d_fault: n=%0d cause=%b want %0d %b", n, o.fault_cnt, o.cause, e.fault, e.cause);
            end
            total++;
            if (o.wb_cnt !== int'(e.wb) || (e.wb && (o.wb_rd !== e.rd || o.wb_data !== e.data))) begin
                bad++; $display("FAIL rnd%0d_wb: n=%0d rd=%0d data=%h want %0d %0d %h",
                                n, o.wb_cnt, o.wb_rd, o.wb_data, e.wb, e.rd, e.data);
            end
            total++;
            if (o.req_cycles !== e.req_cycles || o.stall_cycles !== e.stall_cycles || o.done !== 1'b1) begin
                bad++; $display("FAIL rnd%0d_cycles: req=%0d stall=%0d done=%b want %0d %0d 1",
                                n, o.req_cycles, o.stall_cycles, o.done, e.req_cycles, e.stall_cycles);
            end
            total++;
            if (e.req_cycles != 0 && (o.maddr !== e.maddr || o.be !== e.be || o.we !== e.we ||
                                      (e.we && o.wdata !== e.wdata) || o.stable !== 1'b1)) begin
                bad++; $display("FAIL rnd%0d_bus: addr=%h be=%b we=%b wdata=%h want %h %b %b %h",
                                n, o.maddr, o.be, o.we, o.wdata, e.maddr, e.be, e.we, e.wdata);
            end
            total++;
            if (bus.wb_data !== held_wb) begin
                bad++; $display("FAIL rnd%0d_hold: got %h want %h", n, bus.wb_data, held_wb);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        held_wb = RWB;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.store_data = '0; bus.rd = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_lb();
        test_lhu_delayed();
        test_sb();
        test_faults();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
